// File: rtl/pacman_pkg.sv
// Shared Pac-Man video constants, pixel-code type, maze FSM states and the
// pixel-code to colour mapping used by the maze background stage.
package pacman_pkg;

  localparam logic [7:0] BLK = 8'h00;
  localparam logic [7:0] BLU = 8'h03;
  localparam logic [7:0] CRM = 8'hFE;
  localparam logic [7:0] PNK = 8'hF6;

  localparam int MAZE_W      = 240;
  localparam int MAZE_H      = 264;
  localparam int MAZE_PIXELS = 63360;
  localparam int ADDRESS_MAX = 65535;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DRAW,
    ST_NEXT,
    ST_DONE
  } maze_state_t;

  typedef logic [1:0] pix_code_t;

  function automatic logic [7:0] pix_color(input pix_code_t code);
    unique case (code)
      2'd0:    return BLK;
      2'd1:    return BLU;
      2'd2:    return CRM;
      default: return PNK;
    endcase
  endfunction

endpackage

// File: rtl/maze_renderer_if.sv
// Compositor/tile-map side signals of the maze renderer; slave is the renderer.
interface maze_renderer_if;
  logic        render_req;
  logic        frame_start;
  logic [10:0] tile_rd_addr;
  logic [4:0]  tile_rd_data;
  logic [15:0] address;
  logic [7:0]  maze_color;
  logic        busy;
  logic        frame_swapped;

  modport master (
    output render_req, frame_start, tile_rd_data, address,
    input  tile_rd_addr, maze_color, busy, frame_swapped
  );

  modport slave (
    input  render_req, frame_start, tile_rd_data, address,
    output tile_rd_addr, maze_color, busy, frame_swapped
  );
endinterface

// File: rtl/maze_tile_rom.sv
// Combinational 8x8 tile bitmap ROM: 32 tile codes, 2-bit pixel code per {code, py, px}.
module maze_tile_rom
  import pacman_pkg::*;
(
  input  logic [4:0] code,
  input  logic [2:0] py,
  input  logic [2:0] px,
  output pix_code_t  pix
);

  logic [2:0] edge_w;

  always_comb begin
    pix    = 2'd0;
    edge_w = code[4] ? 3'd2 : 3'd1;
    case (code)
      5'd0: pix = 2'd0;
      5'd1: pix = 2'd1;
      5'd2: if ((px == 3'd3 || px == 3'd4) && (py == 3'd3 || py == 3'd4)) pix = 2'd2;
      5'd3: if (px >= 3'd2 && px <= 3'd5 && py >= 3'd2 && py <= 3'd5) pix = 2'd2;
      5'd4: if (py == 3'd3 || py == 3'd4) pix = 2'd3;
      // Remaining codes: wall edges selected by code[3:0], code[4] doubles thickness.
      default:
        if ((code[0] && py < edge_w) || (code[1] && py > 3'd7 - edge_w) ||
            (code[2] && px < edge_w) || (code[3] && px > 3'd7 - edge_w))
          pix = 2'd1;
    endcase
  end

endmodule

// File: rtl/maze_renderer.sv
// Maze background stage: renders the tile map into a back pixel buffer and serves
// registered colours from the front buffer; buffers swap only on frame_start.
module maze_renderer
  import pacman_pkg::*;
#(
  parameter int COLS       = MAZE_W / 8,
  parameter int ROWS       = MAZE_H / 8,
  parameter int ROW_OFFSET = 3
) (
  input  logic            clk,
  input  logic            rst,
  maze_renderer_if.slave  mz
);

  localparam int BUF_H   = ROWS * 8;
  localparam int BUF_PIX = COLS * ROWS * 64;
  localparam int AW      = $clog2(BUF_PIX);

  localparam logic [15:0] H16      = 16'(BUF_H);
  localparam logic [15:0] PIX16    = 16'(BUF_PIX);
  localparam logic [4:0]  LAST_COL = 5'(COLS - 1);
  localparam logic [5:0]  LAST_ROW = 6'(ROWS - 1);
  localparam logic [10:0] COLS11   = 11'(COLS);
  localparam logic [10:0] OFF11    = 11'(ROW_OFFSET);

  maze_state_t state, state_nxt;
  logic [4:0]  col, col_inc;
  logic [5:0]  row, row_inc;
  logic [2:0]  px, py;
  logic [4:0]  tile_code;
  logic        front_sel, valid, pending;
  logic        last_tile, tile_end, swap, we;
  logic [15:0] wr_addr;
  logic [AW-1:0] wr_idx, rd_idx;
  pix_code_t   rom_pix, rd0, rd1;
  logic        sel_q, blank_q;

  pix_code_t bank0 [BUF_PIX];
  pix_code_t bank1 [BUF_PIX];

  function automatic logic [10:0] tile_addr(input logic [5:0] r, input logic [4:0] c);
    return ({5'd0, r} + OFF11) * COLS11 + {6'd0, c};
  endfunction

  assign last_tile = (row == LAST_ROW) && (col == LAST_COL);
  assign tile_end  = (px == 3'd7) && (py == 3'd7);
  assign col_inc   = (col == LAST_COL) ? '0 : col + 5'd1;
  assign row_inc   = (col == LAST_COL) ? row + 6'd1 : row;
  assign swap      = (state == ST_DONE) && mz.frame_start;
  assign mz.busy   = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (mz.render_req) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_DRAW;
      ST_DRAW:  if (tile_end) state_nxt = ST_NEXT;
      ST_NEXT:  state_nxt = last_tile ? ST_DONE : ST_FETCH;
      ST_DONE:  if (mz.frame_start) state_nxt = (pending || mz.render_req) ? ST_FETCH : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col              <= '0;
      row              <= '0;
      px               <= '0;
      py               <= '0;
      tile_code        <= '0;
      front_sel        <= 1'b0;
      valid            <= 1'b0;
      pending          <= 1'b0;
      mz.tile_rd_addr  <= '0;
      mz.frame_swapped <= 1'b0;
    end else begin
      mz.frame_swapped <= 1'b0;
      // A request landing on the swap cycle restarts the render directly instead.
      if (mz.render_req && state != ST_IDLE && !swap) pending <= 1'b1;
      case (state)
        ST_IDLE:
          if (mz.render_req) begin
            pending         <= 1'b0;
            col             <= '0;
            row             <= '0;
            mz.tile_rd_addr <= tile_addr(6'd0, 5'd0);
          end
        ST_WAIT: begin
          tile_code <= mz.tile_rd_data;
          px        <= '0;
          py        <= '0;
        end
        ST_DRAW: begin
          px <= px + 3'd1;
          if (px == 3'd7) py <= py + 3'd1;
        end
        ST_NEXT: begin
          col             <= col_inc;
          row             <= row_inc;
          mz.tile_rd_addr <= tile_addr(row_inc, col_inc);
        end
        ST_DONE:
          if (mz.frame_start) begin
            front_sel        <= ~front_sel;
            valid            <= 1'b1;
            mz.frame_swapped <= 1'b1;
            pending          <= 1'b0;
            col              <= '0;
            row              <= '0;
            mz.tile_rd_addr  <= tile_addr(6'd0, 5'd0);
          end
        default: ;
      endcase
    end
  end

  maze_tile_rom u_rom (
    .code (tile_code),
    .py   (py),
    .px   (px),
    .pix  (rom_pix)
  );

  assign we      = (state == ST_DRAW);
  assign wr_addr = {8'd0, col, px} * H16 + {7'd0, row, py};
  assign wr_idx  = AW'(wr_addr);
  assign rd_idx  = AW'(mz.address);

  // Each bank is single-port: written while it is the back buffer, read while front.
  always_ff @(posedge clk) begin
    if (front_sel) begin
      if (we) bank0[wr_idx] <= rom_pix;
    end else begin
      rd0 <= bank0[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!front_sel) begin
      if (we) bank1[wr_idx] <= rom_pix;
    end else begin
      rd1 <= bank1[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      sel_q   <= front_sel;
      blank_q <= !(valid && (mz.address < PIX16));
    end
  end

  assign mz.maze_color = blank_q ? BLK : pix_color(sel_q ? rd1 : rd0);

endmodule

// File: tb/tb_maze_renderer.sv
// Directed bench for maze_renderer on a reduced 6x6-tile map (48x48 pixel buffer).
module tb_maze_renderer;

  localparam int NC          = 6;
  localparam int NR          = 6;
  localparam int OFFS        = 3;
  localparam int RENDER_WAIT = NC * NR * 67 + 20;

  localparam logic [7:0] C_BLK = 8'h00;
  localparam logic [7:0] C_BLU = 8'h03;
  localparam logic [7:0] C_CRM = 8'hFE;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  c;
  } rd_t;

  logic clk;
  logic rst;
  logic [4:0] tmap [2048];
  rd_t sb [$];
  int compared;
  int mismatched;
  int swap_cnt;
  int swap_base;

  maze_renderer_if mz ();

  maze_renderer #(.COLS(NC), .ROWS(NR), .ROW_OFFSET(OFFS)) dut (
    .clk (clk),
    .rst (rst),
    .mz  (mz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mz.tile_rd_data <= tmap[mz.tile_rd_addr];

  always @(negedge clk) if (mz.frame_swapped === 1'b1) swap_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic retire();
    rd_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("read@%0d", e.a), {24'd0, mz.maze_color}, {24'd0, e.c});
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] c);
    @(negedge clk);
    retire();
    mz.address = a;
    sb.push_back('{a, c});
  endtask

  task automatic rd_flush();
    @(negedge clk);
    retire();
  endtask

  task automatic fill_map(input logic [4:0] code);
    for (int i = 0; i < 2048; i++) tmap[i] = code;
  endtask

  task automatic pulse_req();
    @(negedge clk) mz.render_req = 1'b1;
    @(negedge clk) mz.render_req = 1'b0;
  endtask

  task automatic swap_pulse(input string tag, input logic exp_swap);
    @(negedge clk) mz.frame_start = 1'b1;
    @(negedge clk) mz.frame_start = 1'b0;
    check({tag, " frame_swapped"}, {31'd0, mz.frame_swapped}, {31'd0, exp_swap});
    @(negedge clk);
    check({tag, " pulse width"}, {31'd0, mz.frame_swapped}, 32'd0);
  endtask

  function automatic logic [15:0] pa(input int x, input int y);
    return 16'(x * NR * 8 + y);
  endfunction

  initial begin
    compared       = 0;
    mismatched     = 0;
    swap_cnt       = 0;
    rst            = 1'b1;
    mz.render_req  = 1'b0;
    mz.frame_start = 1'b0;
    mz.address     = '0;
    fill_map(5'd0);

    // Reset values
    #1;
    check("rst tile_rd_addr", {21'd0, mz.tile_rd_addr}, 32'd0);
    check("rst busy", {31'd0, mz.busy}, 32'd0);
    check("rst frame_swapped", {31'd0, mz.frame_swapped}, 32'd0);
    check("rst maze_color", {24'd0, mz.maze_color}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Nothing rendered yet: every address reads black
    for (int a = 0; a < 65536; a += 97) rd(16'(a), C_BLK);
    rd(16'hFFFF, C_BLK);
    rd_flush();
    check("idle busy", {31'd0, mz.busy}, 32'd0);
    check("idle swaps", swap_cnt, 32'd0);

    // All-wall render, swap with a read coinciding with frame_start
    fill_map(5'd1);
    pulse_req();
    check("fetch tile_rd_addr", {21'd0, mz.tile_rd_addr}, 32'(OFFS * NC));
    check("render busy", {31'd0, mz.busy}, 32'd1);
    repeat (RENDER_WAIT) @(negedge clk);
    check("done busy", {31'd0, mz.busy}, 32'd1);
    mz.address     = 16'd0;
    mz.frame_start = 1'b1;
    @(negedge clk) mz.frame_start = 1'b0;
    check("wall frame_swapped", {31'd0, mz.frame_swapped}, 32'd1);
    check("old front on swap", {24'd0, mz.maze_color}, {24'd0, C_BLK});
    @(negedge clk);
    check("wall pulse width", {31'd0, mz.frame_swapped}, 32'd0);
    check("new front after swap", {24'd0, mz.maze_color}, {24'd0, C_BLU});
    check("wall busy after swap", {31'd0, mz.busy}, 32'd0);
    rd(16'd0, C_BLU);
    rd(pa(NC * 8 - 1, NR * 8 - 1), C_BLU);
    rd(16'd1234, C_BLU);
    rd(16'(NC * NR * 64), C_BLK);
    rd(16'hFFFF, C_BLK);
    rd_flush();
    check("wall swaps", swap_cnt, 32'd1);

    // Dot tile at col 2 / row 5; frame_start mid-render must be ignored
    fill_map(5'd0);
    tmap[(5 + OFFS) * NC + 2] = 5'd2;
    pulse_req();
    repeat (1200) @(negedge clk);
    swap_pulse("mid-render", 1'b0);
    check("mid-render busy", {31'd0, mz.busy}, 32'd1);
    rd(16'd0, C_BLU);
    rd_flush();
    repeat (RENDER_WAIT - 1200) @(negedge clk);
    swap_pulse("dot", 1'b1);
    rd(pa(19, 43), C_CRM);
    rd(pa(20, 44), C_CRM);
    rd(pa(19, 42), C_BLK);
    rd(pa(21, 43), C_BLK);
    rd(16'd0, C_BLK);
    rd_flush();
    check("dot swaps", swap_cnt, 32'd2);

    // Three requests during a render collapse into one extra render
    fill_map(5'd3);
    swap_base = swap_cnt;
    pulse_req();
    repeat (300) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      pulse_req();
      repeat (200) @(negedge clk);
    end
    repeat (RENDER_WAIT) @(negedge clk);
    swap_pulse("pending first", 1'b1);
    check("pending rerender busy", {31'd0, mz.busy}, 32'd1);
    rd(pa(2, 2), C_CRM);
    rd(pa(1, 2), C_BLK);
    rd(pa(5, 5), C_CRM);
    rd(pa(6, 5), C_BLK);
    rd(pa(10, 2), C_CRM);
    rd_flush();
    repeat (RENDER_WAIT) @(negedge clk);
    // Request on the swap cycle starts another render straight away
    mz.frame_start = 1'b1;
    mz.render_req  = 1'b1;
    @(negedge clk);
    mz.frame_start = 1'b0;
    mz.render_req  = 1'b0;
    check("pending second frame_swapped", {31'd0, mz.frame_swapped}, 32'd1);
    check("req on swap busy", {31'd0, mz.busy}, 32'd1);
    @(negedge clk);
    check("two swaps for burst", swap_cnt - swap_base, 32'd2);
    rd(pa(2, 2), C_CRM);
    rd_flush();

    // Asynchronous reset mid-render
    repeat (1000) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", {31'd0, mz.busy}, 32'd0);
    check("async rst frame_swapped", {31'd0, mz.frame_swapped}, 32'd0);
    check("async rst maze_color", {24'd0, mz.maze_color}, 32'd0);
    check("async rst tile_rd_addr", {21'd0, mz.tile_rd_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(pa(2, 2), C_BLK);
    rd(16'd0, C_BLK);
    rd_flush();
    swap_pulse("idle frame_start", 1'b0);
    check("post-reset busy", {31'd0, mz.busy}, 32'd0);
    rd(pa(2, 2), C_BLK);
    rd_flush();

    // Recovery render after reset
    fill_map(5'd1);
    pulse_req();
    repeat (RENDER_WAIT) @(negedge clk);
    swap_pulse("recovery", 1'b1);
    rd(pa(2, 2), C_BLU);
    rd(pa(NC * 8 - 1, NR * 8 - 1), C_BLU);
    rd(16'(NC * NR * 64), C_BLK);
    rd_flush();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
